inst_mem_loader: RTL and testbench

- Parametrised, programmable instruction memory. Next generation of the fixed combinational instruction ROM.
- A host streams a program in through a valid/ready load port. The core then fetches through a registered read port with 1-cycle latency.
- Fetches beyond the loaded program length return NOP and raise a fault flag.
- Sits between the testbench/boot loader and the fetch stage of the processor.

---
 rtl/inst_mem_pkg.sv | 18 +
 rtl/inst_mem_array.sv | 25 ++
 rtl/inst_mem_loader.sv | 114 +++++++++++
 tb/tb_inst_mem_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the programmable instruction memory.
package inst_mem_pkg;

    localparam int unsigned IW_DEF = 9;
    localparam int unsigned AW_DEF = 8;

    typedef logic [IW_DEF-1:0] inst_t;
    typedef logic [AW_DEF-1:0] addr_t;

    localparam inst_t NOP_DEFAULT = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x IW RAM: synchronous write, registered read, array not reset.
module inst_mem_array #(
    parameter int unsigned IW    = 9,
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Programmable instruction memory: streamed load port, 1-cycle registered fetch
// port; fetches beyond the loaded length return NOP with addr_fault.
module inst_mem_loader
    import inst_mem_pkg::*;
#(
    parameter int unsigned   IW    = 9,
    parameter int unsigned   AW    = 8,
    parameter int unsigned   DEPTH = 2**AW,
    parameter logic [IW-1:0] NOP   = '0
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          load_start,
    input  logic          prog_valid,
    input  logic [IW-1:0] prog_data,
    input  logic          prog_last,
    output logic          prog_ready,
    output logic          load_done,
    output logic [AW:0]   loaded_count,
    input  logic          fetch_en,
    input  logic [AW-1:0] Address,
    output logic [IW-1:0] Instruction,
    output logic          inst_valid,
    output logic          addr_fault
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH-1);

    state_t        state;
    logic [AW-1:0] wp;
    logic          we;
    logic          in_range;
    logic          fetch_ok;
    logic          re;
    logic          sel_nop;
    logic [IW-1:0] rdata;

    // prog_ready is high exactly while in LOAD, so it doubles as the state qualifier
    assign we       = prog_ready & prog_valid & ~load_start;
    assign in_range = {1'b0, Address} < loaded_count;
    assign fetch_ok = fetch_en & (state == RUN);
    assign re       = fetch_ok & in_range;

    inst_mem_array #(
        .IW    (IW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (CLK),
        .we    (we),
        .waddr (wp),
        .wdata (prog_data),
        .re    (re),
        .raddr (Address),
        .rdata (rdata)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            wp           <= '0;
            prog_ready   <= 1'b0;
            load_done    <= 1'b0;
            loaded_count <= '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (load_start) begin
                        state        <= LOAD;
                        wp           <= '0;
                        prog_ready   <= 1'b1;
                        load_done    <= 1'b0;
                        loaded_count <= '0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wp <= '0;
                    end else if (prog_valid) begin
                        wp <= wp + 1'b1;
                        if (prog_last || ({1'b0, wp} == LAST_IDX)) begin
                            state        <= RUN;
                            prog_ready   <= 1'b0;
                            load_done    <= 1'b1;
                            loaded_count <= {1'b0, wp} + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    prog_ready <= 1'b0;
                end
            endcase
        end
    end

    // Instruction is the registered array word unless the last fetch was masked;
    // both sources hold when no fetch is requested.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            inst_valid <= 1'b0;
            addr_fault <= 1'b0;
            sel_nop    <= 1'b1;
        end else begin
            inst_valid <= fetch_ok;
            addr_fault <= fetch_ok & ~in_range;
            if (fetch_en)
                sel_nop <= ~re;
        end
    end

    assign Instruction = sel_nop ? NOP : rdata;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: AW=8 instance plus an AW=3 instance for full-depth loads.
module tb_inst_mem_loader;

    typedef struct {
        logic       v;
        logic [8:0] ins;
        logic       f;
    } exp_t;

    int tests = 0;
    int fails = 0;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    // Wide instance
    logic       load_start, prog_valid, prog_last, prog_ready, load_done, fetch_en;
    logic [8:0] prog_data, Instruction;
    logic [8:0] loaded_count;
    logic [7:0] Address;
    logic       inst_valid, addr_fault;

    // Small instance (AW=3, DEPTH=8)
    logic       s_load_start, s_prog_valid, s_prog_last, s_prog_ready, s_load_done, s_fetch_en;
    logic [8:0] s_prog_data, s_Instruction;
    logic [3:0] s_loaded_count;
    logic [2:0] s_Address;
    logic       s_inst_valid, s_addr_fault;

    inst_mem_loader #(.IW(9), .AW(8)) dut (
        .CLK(CLK), .Reset(Reset), .load_start(load_start), .prog_valid(prog_valid),
        .prog_data(prog_data), .prog_last(prog_last), .prog_ready(prog_ready),
        .load_done(load_done), .loaded_count(loaded_count), .fetch_en(fetch_en),
        .Address(Address), .Instruction(Instruction), .inst_valid(inst_valid),
        .addr_fault(addr_fault)
    );

    inst_mem_loader #(.IW(9), .AW(3), .DEPTH(8)) dut_s (
        .CLK(CLK), .Reset(Reset), .load_start(s_load_start), .prog_valid(s_prog_valid),
        .prog_data(s_prog_data), .prog_last(s_prog_last), .prog_ready(s_prog_ready),
        .load_done(s_load_done), .loaded_count(s_loaded_count), .fetch_en(s_fetch_en),
        .Address(s_Address), .Instruction(s_Instruction), .inst_valid(s_inst_valid),
        .addr_fault(s_addr_fault)
    );

    exp_t q8[$];
    exp_t q3[$];
    logic req8 = 1'b0;
    logic req3 = 1'b0;

    always @(posedge CLK) begin
        req8 <= fetch_en;
        req3 <= s_fetch_en;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_fetch(input string tag, input exp_t e,
                                 input logic v, input logic [8:0] ins, input logic f);
        check({tag, ".inst_valid"}, 32'(v), 32'(e.v));
        check({tag, ".Instruction"}, 32'(ins), 32'(e.ins));
        check({tag, ".addr_fault"}, 32'(f), 32'(e.f));
    endtask

    // Monitors: one expectation per fetch request, checked the cycle after
    always @(negedge CLK) begin
        exp_t e;
        if (req8) begin
            if (q8.size() == 0) begin
                tests++; fails++;
                $display("FAIL fetch8: response with empty scoreboard");
            end else begin
                e = q8.pop_front();
                compare_fetch("fetch8", e, inst_valid, Instruction, addr_fault);
            end
        end else if (inst_valid) begin
            tests++; fails++;
            $display("FAIL fetch8: unexpected inst_valid=1 expected 0");
        end
        if (req3) begin
            if (q3.size() == 0) begin
                tests++; fails++;
                $display("FAIL fetch3: response with empty scoreboard");
            end else begin
                e = q3.pop_front();
                compare_fetch("fetch3", e, s_inst_valid, s_Instruction, s_addr_fault);
            end
        end else if (s_inst_valid) begin
            tests++; fails++;
            $display("FAIL fetch3: unexpected inst_valid=1 expected 0");
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [8:0] d, input logic last);
        prog_valid = 1'b1;
        prog_data  = d;
        prog_last  = last;
        tick();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a, input logic v, input logic [8:0] ins, input logic f);
        exp_t e;
        e.v = v; e.ins = ins; e.f = f;
        q8.push_back(e);
        fetch_en = 1'b1;
        Address  = a;
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic s_fetch(input logic [2:0] a, input logic [8:0] ins);
        exp_t e;
        e.v = 1'b1; e.ins = ins; e.f = 1'b0;
        q3.push_back(e);
        s_fetch_en = 1'b1;
        s_Address  = a;
        tick();
        s_fetch_en = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        load_start = 0; prog_valid = 0; prog_data = '0; prog_last = 0; fetch_en = 0; Address = '0;
        s_load_start = 0; s_prog_valid = 0; s_prog_data = '0; s_prog_last = 0; s_fetch_en = 0; s_Address = '0;
        tick(); tick();

        check("rst.prog_ready", 32'(prog_ready), 0);
        check("rst.load_done", 32'(load_done), 0);
        check("rst.loaded_count", 32'(loaded_count), 0);
        check("rst.Instruction", 32'(Instruction), 0);
        check("rst.inst_valid", 32'(inst_valid), 0);
        check("rst.addr_fault", 32'(addr_fault), 0);
        Reset = 1'b0;
        tick();

        // Basic load and fetch
        start_load();
        check("basic.prog_ready", 32'(prog_ready), 1);
        send(9'h101, 0); send(9'h0AA, 0); send(9'h1FF, 1);
        check("basic.load_done", 32'(load_done), 1);
        check("basic.loaded_count", 32'(loaded_count), 3);
        check("basic.prog_ready_run", 32'(prog_ready), 0);
        // prog_valid in RUN must not write
        send(9'h1EE, 0);
        check("basic.count_hold", 32'(loaded_count), 3);
        fetch(0, 1, 9'h101, 0);
        fetch(1, 1, 9'h0AA, 0);
        fetch(2, 1, 9'h1FF, 0);
        // Out-of-range fetches
        fetch(3, 1, 9'h000, 1);
        fetch(255, 1, 9'h000, 1);
        fetch(0, 1, 9'h101, 0);
        tick();
        check("hold.Instruction", 32'(Instruction), 9'h101);

        // Backpressure gaps
        start_load();
        send(9'h011, 0);
        prog_data = 9'h0FF; tick();
        send(9'h022, 0);
        prog_data = 9'h0EE; tick();
        send(9'h033, 0);
        prog_data = 9'h0DD; tick();
        send(9'h044, 1);
        check("bp.loaded_count", 32'(loaded_count), 4);
        fetch(0, 1, 9'h011, 0);
        fetch(1, 1, 9'h022, 0);
        fetch(2, 1, 9'h033, 0);
        fetch(3, 1, 9'h044, 0);
        fetch(4, 1, 9'h000, 1);
        tick();

        // Reload with fetch during LOAD, plus restart inside LOAD
        start_load();
        check("reload.loaded_count", 32'(loaded_count), 0);
        check("reload.load_done", 32'(load_done), 0);
        fetch(0, 0, 9'h000, 0);
        load_start = 1'b1;
        send(9'h1AB, 0);
        load_start = 1'b0;
        send(9'h0C3, 0);
        send(9'h13C, 1);
        check("reload.count", 32'(loaded_count), 2);
        fetch(0, 1, 9'h0C3, 0);
        fetch(1, 1, 9'h13C, 0);
        fetch(2, 1, 9'h000, 1);
        tick();

        // Full-depth auto transition on the small instance
        s_load_start = 1'b1; tick(); s_load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                check("wrap.ready_before_last", 32'(s_prog_ready), 1);
                check("wrap.done_before_last", 32'(s_load_done), 0);
            end
            s_prog_valid = 1'b1; s_prog_last = 1'b0; s_prog_data = 9'(9'h0A0 + i);
            tick();
        end
        s_prog_valid = 1'b0;
        check("wrap.prog_ready", 32'(s_prog_ready), 0);
        check("wrap.load_done", 32'(s_load_done), 1);
        check("wrap.loaded_count", 32'(s_loaded_count), 8);
        s_fetch(7, 9'h0A7);
        s_fetch(0, 9'h0A0);
        tick();

        // Reset mid-load
        start_load();
        send(9'h001, 0); send(9'h002, 0);
        Reset = 1'b1;
        #1;
        check("rstmid.prog_ready", 32'(prog_ready), 0);
        check("rstmid.load_done", 32'(load_done), 0);
        check("rstmid.loaded_count", 32'(loaded_count), 0);
        check("rstmid.Instruction", 32'(Instruction), 0);
        check("rstmid.inst_valid", 32'(inst_valid), 0);
        check("rstmid.addr_fault", 32'(addr_fault), 0);
        tick();
        Reset = 1'b0;
        tick();
        fetch(0, 0, 9'h000, 0);
        start_load();
        send(9'h155, 1);
        check("rstmid.reload_count", 32'(loaded_count), 1);
        fetch(0, 1, 9'h155, 0);
        fetch(1, 1, 9'h000, 1);
        tick(); tick();

        check("sb.q8_empty", 32'(q8.size()), 0);
        check("sb.q3_empty", 32'(q3.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
